uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Asynchronous UART receiver; pairs with uart_tx on the same peripheral clock/prescaler.
// - Oversamples rx (16x, or 8x when u2x=1) and deframes 5..9 data bits, optional parity, 1/2 stop bits.
// - Holds one received word in a single-entry buffer; reports frame, parity and overrun errors.
// PARAMETERS
// - MAX_WORD_LEN  9  widest data word supported; data output width
// - SYNC_STAGES   2  flops in the rx input synchronizer (>=2)
// PORTS
// - clk         in   1   peripheral/oversample clock from prescaler (one tick = 1/16 bit, 1/8 if u2x)
// - rst         in   1   asynchronous reset, active-high
// - rxen        in   1   receiver enable; low = held in reset state (synchronous clear)
// - rx          in   1   serial line, idle high, asynchronous to clk
// - wordlen     in   4   data bits: 5..9; any other value = 8
// - parity      in   2   00 none, 01 even, 10 odd, 11 none
// - stopbits    in   1   0 = one stop bit, 1 = two (only first is checked)
// - u2x         in   1   double speed: 8 ticks per bit instead of 16
// - rd          in   1   one-clk read strobe, synchronous to clk; pops the buffer
// - data        out  9   received word, LSB first on line, zero-extended above wordlen
// - buffull     out  1   1 = data valid and unread
// - frame_err   out  1   first stop bit sampled 0 for the word in data
// - parity_err  out  1   parity mismatch for the word in data
// - overrun     out  1   a frame completed while buffull=1; sticky until rd
// BEHAVIOUR
// - Reset (rst or rxen=0): state IDLE, data=0, buffull=0, all error flags 0, sync flops=1.
// - Sampling: N = u2x ? 8 : 16 ticks per bit; sample point M = N/2; bit value = majority of
//   synchronized rx at ticks M-1, M, M+1 of each bit.
// - FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
//   IDLE: on synchronized falling edge, clear tick counter, latch wordlen/parity/u2x -> START.
//   START: at sample point, vote 0 -> continue (counter realigned to bit boundary) -> DATA;
//          vote 1 = glitch -> IDLE, nothing reported.
//   DATA: shift in latched wordlen bits LSB first; PARITY: sample one bit, compare vs XOR of data
//   (even: XOR of data^parity bit must be 0; odd: must be 1).
//   STOP: at sample point of first stop bit, complete frame, return to IDLE immediately
//   (second stop bit is not waited for; receiver re-arms on next falling edge).
// - Completion (same clk as stop sample, registered; visible next clk):
//   buffull=0: load data, frame_err, parity_err; buffull<=1.
//   buffull=1 and no rd: new frame discarded, old data/flags kept, overrun<=1.
//   rd in same clk as completion: treated as read-then-load; no overrun.
// - rd with buffull=1: buffull<=0, overrun<=0, frame_err/parity_err<=0; data holds last value.
//   rd with buffull=0: ignored.
// - Latency: line edge -> IDLE exit = SYNC_STAGES+1 clk; stop-bit sample -> buffull=1 is 1 clk.
// - Frame error still loads data (flag set); a break (all zeros) yields data=0, frame_err=1.
// - Config inputs changing mid-frame have no effect until next start bit.
// - rst mid-frame: abort, no output change beyond reset values; rxen falling same as reset.
// STRUCTURE
// - uart_pkg: FSM state encoding, parity codes (PAR_NONE/EVEN/ODD), OSR_NORMAL=16, OSR_U2X=8,
//   word-length clamp function shared with uart_tx.
// - Sub-module uart_rx_sampler: SYNC_STAGES synchronizer, falling-edge detect, 3-sample
//   majority vote; outputs rx_sync, fall_edge, vote.
// - uart_rx top: tick/bit counters, FSM, shift register, parity accumulator, output buffer.
// TESTING
// - 8N1, u2x=0, send 0xA5 -> data=0x0A5, buffull=1 one clk after stop sample, all errors 0.
// - 7E1, send 0x41 with parity bit 1 (wrong) -> data=0x041, parity_err=1, frame_err=0.
// - 8N1, stop bit driven 0 for 0x3C -> data=0x03C, frame_err=1; rd -> buffull=0, flags 0.
// - rx low for 4 ticks then high (u2x=0) -> FSM back to IDLE, buffull stays 0.
// - Two 8N1 frames 0x11,0x22 with no rd -> data=0x011, overrun=1; rd at 2nd completion -> 0x022, overrun=0.
// - u2x=1, 9O2, send 0x1FF with correct parity, back-to-back frames -> both received, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity codes, oversampling ratios
// and small helpers common to uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OSR_NORMAL = 16;
  localparam int OSR_U2X    = 8;

  // Legal word lengths are 5..9; anything else falls back to 8 bits.
  function automatic logic [3:0] word_len_clamp(input logic [3:0] wl);
    logic [3:0] res;
    if ((wl >= 4'd5) && (wl <= 4'd9)) begin
      res = wl;
    end else begin
      res = 4'd8;
    end
    return res;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // acc is the XOR of the data bits; pbit is the received parity bit.
  function automatic logic parity_mismatch(input logic [1:0] mode, input logic acc,
                                           input logic pbit);
    logic res;
    case (mode)
      PAR_EVEN: res = acc ^ pbit;
      PAR_ODD:  res = ~(acc ^ pbit);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for uart_rx: synchronizer, falling-edge detect and a 3-sample
// majority vote built from two captured samples plus the live synchronized value.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rx,
  input  logic sample_a,
  input  logic sample_b,
  output logic rx_sync,
  output logic fall_edge,
  output logic vote
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   samp_a_r;
  logic                   samp_b_r;

  // Synchronizer chain, edge history and the two early vote samples; all idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r   <= {SYNC_STAGES{1'b1}};
      prev_r   <= 1'b1;
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else if (clr) begin
      sync_r   <= {SYNC_STAGES{1'b1}};
      prev_r   <= 1'b1;
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
      prev_r <= sync_r[SYNC_STAGES-1];
      if (sample_a) begin
        samp_a_r <= sync_r[SYNC_STAGES-1];
      end
      if (sample_b) begin
        samp_b_r <= sync_r[SYNC_STAGES-1];
      end
    end
  end

  assign rx_sync   = sync_r[SYNC_STAGES-1];
  assign fall_edge = prev_r & ~rx_sync;
  assign vote      = majority3(samp_a_r, samp_b_r, rx_sync);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 5..9 data bits, optional parity, single-entry
// receive buffer with frame, parity and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int MAX_WORD_LEN = 9,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rxen,
  input  logic                    rx,
  input  logic [3:0]              wordlen,
  input  logic [1:0]              parity,
  input  logic                    stopbits,
  input  logic                    u2x,
  input  logic                    rd,
  output logic [MAX_WORD_LEN-1:0] data,
  output logic                    buffull,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun
);

  rx_state_e               state_r;
  logic [3:0]              tick_r;
  logic [3:0]              bitcnt_r;
  logic [3:0]              wl_r;
  logic [1:0]              par_r;
  logic                    u2x_r;
  logic [MAX_WORD_LEN-1:0] shift_r;
  logic                    par_acc_r;
  logic                    par_bit_r;
  logic [MAX_WORD_LEN-1:0] data_r;
  logic                    buffull_r;
  logic                    fe_r;
  logic                    pe_r;
  logic                    ovr_r;

  logic                    rx_sync_s;
  logic                    fall_s;
  logic                    vote_s;
  logic [3:0]              last_tick_s;
  logic [3:0]              mid_s;
  logic                    sample_a_s;
  logic                    sample_b_s;
  logic                    decide_s;
  logic                    bit_end_s;
  logic                    par_en_s;
  logic                    complete_s;
  logic [3:0]              shamt_s;
  logic [MAX_WORD_LEN-1:0] word_s;
  logic                    pe_new_s;
  logic                    unused_s;

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .clr      (~rxen),
    .rx       (rx),
    .sample_a (sample_a_s),
    .sample_b (sample_b_s),
    .rx_sync  (rx_sync_s),
    .fall_edge(fall_s),
    .vote     (vote_s)
  );

  // The second stop bit is never waited for, so stopbits has no effect on reception.
  assign unused_s = ^{stopbits, rx_sync_s};

  // Tick decoding against the latched oversampling ratio, and word extraction.
  always_comb begin
    if (u2x_r) begin
      last_tick_s = 4'(OSR_U2X - 1);
      mid_s       = 4'(OSR_U2X / 2);
    end else begin
      last_tick_s = 4'(OSR_NORMAL - 1);
      mid_s       = 4'(OSR_NORMAL / 2);
    end
    sample_a_s = (tick_r == (mid_s - 4'd1));
    sample_b_s = (tick_r == mid_s);
    decide_s   = (state_r != ST_IDLE) && (tick_r == (mid_s + 4'd1));
    bit_end_s  = (tick_r == last_tick_s);
    par_en_s   = (par_r == PAR_EVEN) || (par_r == PAR_ODD);
    complete_s = (state_r == ST_STOP) && decide_s;
    // New bits enter at the MSB, so the word sits in the top wl_r bits.
    shamt_s    = 4'(MAX_WORD_LEN) - wl_r;
    word_s     = shift_r >> shamt_s;
    if (par_en_s) begin
      pe_new_s = parity_mismatch(par_r, par_acc_r, par_bit_r);
    end else begin
      pe_new_s = 1'b0;
    end
  end

  // Deframing FSM: tick counter, bit counter, shift register and parity accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tick_r    <= 4'd0;
      bitcnt_r  <= 4'd0;
      wl_r      <= 4'd8;
      par_r     <= PAR_NONE;
      u2x_r     <= 1'b0;
      shift_r   <= '0;
      par_acc_r <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (!rxen) begin
      state_r   <= ST_IDLE;
      tick_r    <= 4'd0;
      bitcnt_r  <= 4'd0;
      wl_r      <= 4'd8;
      par_r     <= PAR_NONE;
      u2x_r     <= 1'b0;
      shift_r   <= '0;
      par_acc_r <= 1'b0;
      par_bit_r <= 1'b0;
    end else begin
      if ((state_r != ST_IDLE) && bit_end_s) begin
        tick_r <= 4'd0;
      end else if (state_r != ST_IDLE) begin
        tick_r <= tick_r + 4'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            // The edge cycle itself is tick 0 of the start bit.
            state_r   <= ST_START;
            tick_r    <= 4'd1;
            bitcnt_r  <= 4'd0;
            par_acc_r <= 1'b0;
            wl_r      <= word_len_clamp(wordlen);
            par_r     <= parity;
            u2x_r     <= u2x;
          end
        end
        ST_START: begin
          if (decide_s && vote_s) begin
            state_r <= ST_IDLE;
            tick_r  <= 4'd0;
          end else if (bit_end_s) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide_s) begin
            shift_r   <= {vote_s, shift_r[MAX_WORD_LEN-1:1]};
            par_acc_r <= par_acc_r ^ vote_s;
            bitcnt_r  <= bitcnt_r + 4'd1;
          end
          if (bit_end_s && (bitcnt_r == wl_r)) begin
            state_r <= par_en_s ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (decide_s) begin
            par_bit_r <= vote_s;
          end
          if (bit_end_s) begin
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide_s) begin
            state_r <= ST_IDLE;
            tick_r  <= 4'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tick_r  <= 4'd0;
        end
      endcase
    end
  end

  // Single-entry receive buffer; a read in the completion cycle frees room first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r    <= '0;
      buffull_r <= 1'b0;
      fe_r      <= 1'b0;
      pe_r      <= 1'b0;
      ovr_r     <= 1'b0;
    end else if (!rxen) begin
      data_r    <= '0;
      buffull_r <= 1'b0;
      fe_r      <= 1'b0;
      pe_r      <= 1'b0;
      ovr_r     <= 1'b0;
    end else if (complete_s) begin
      if (!buffull_r || rd) begin
        data_r    <= word_s;
        fe_r      <= ~vote_s;
        pe_r      <= pe_new_s;
        buffull_r <= 1'b1;
        ovr_r     <= 1'b0;
      end else begin
        ovr_r <= 1'b1;
      end
    end else if (rd && buffull_r) begin
      buffull_r <= 1'b0;
      ovr_r     <= 1'b0;
      fe_r      <= 1'b0;
      pe_r      <= 1'b0;
    end
  end

  assign data       = data_r;
  assign buffull    = buffull_r;
  assign frame_err  = fe_r;
  assign parity_err = pe_r;
  assign overrun    = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitch rejection, overrun, read-at-completion and back-to-back frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxen;
  logic       rx;
  logic [3:0] wordlen;
  logic [1:0] parity;
  logic       stopbits;
  logic       u2x;
  logic       rd;
  logic [8:0] data;
  logic       buffull;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rxen      (rxen),
    .rx        (rx),
    .wordlen   (wordlen),
    .parity    (parity),
    .stopbits  (stopbits),
    .u2x       (u2x),
    .rd        (rd),
    .data      (data),
    .buffull   (buffull),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] wl;
    logic [1:0] par;
    logic       u2x;
    logic [8:0] w;
    int         nd;
    logic       has_par;
    logic       pbit;
    logic       stopv;
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      rx = 1'b1;
      rd = 1'b0;
    end
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Drives one frame, n clocks per bit, one bit change per negedge group. rd is
  // pulsed at negedge offset rd_at; buffull is captured at offsets probe_at and probe_at+1.
  task automatic send_word(input logic [8:0] w, input int nd, input logic has_par,
                           input logic pbit, input logic stopv, input int nstop,
                           input int n, input int rd_at, input int probe_at,
                           output logic pr0, output logic pr1);
    logic [15:0] fr;
    int nb;
    fr = 16'h0000;
    fr[0] = 1'b0;
    for (int i = 0; i < nd; i++) fr[1+i] = w[i];
    nb = 1 + nd;
    if (has_par) begin
      fr[nb] = pbit;
      nb++;
    end
    for (int s = 0; s < nstop; s++) begin
      fr[nb] = stopv;
      nb++;
    end
    pr0 = 1'bx;
    pr1 = 1'bx;
    for (int i = 0; i < nb * n; i++) begin
      @(negedge clk);
      rx = fr[i/n];
      rd = (i == rd_at);
      if (i == probe_at) pr0 = buffull;
      if (i == probe_at + 1) pr1 = buffull;
    end
  endtask

  initial begin
    logic p0, p1;
    int   n;

    vecs[0] = '{4'd8,  2'b00, 1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{4'd7,  2'b01, 1'b0, 9'h041, 7, 1'b1, 1'b1, 1'b1, 9'h041, 1'b0, 1'b1};
    vecs[2] = '{4'd8,  2'b00, 1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
    vecs[3] = '{4'd5,  2'b00, 1'b0, 9'h015, 5, 1'b0, 1'b0, 1'b1, 9'h015, 1'b0, 1'b0};
    vecs[4] = '{4'd9,  2'b11, 1'b0, 9'h12D, 9, 1'b0, 1'b0, 1'b1, 9'h12D, 1'b0, 1'b0};
    vecs[5] = '{4'd6,  2'b10, 1'b0, 9'h02A, 6, 1'b1, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b0};
    vecs[6] = '{4'd15, 2'b00, 1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0};
    vecs[7] = '{4'd8,  2'b01, 1'b1, 9'h096, 8, 1'b1, 1'b0, 1'b1, 9'h096, 1'b0, 1'b0};
    vecs[8] = '{4'd8,  2'b00, 1'b0, 9'h000, 8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0};

    rst = 1'b1; rxen = 1'b1; rx = 1'b1; rd = 1'b0;
    wordlen = 4'd8; parity = 2'b00; stopbits = 1'b0; u2x = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_buffull", 32'(buffull), 32'h0);
    check("reset_errs", 32'({frame_err, parity_err, overrun}), 32'h0);
    rst = 1'b0;
    idle(5);

    for (int v = 0; v < 9; v++) begin
      wordlen = vecs[v].wl;
      parity  = vecs[v].par;
      u2x     = vecs[v].u2x;
      n       = vecs[v].u2x ? 8 : 16;
      idle(4);
      send_word(vecs[v].w, vecs[v].nd, vecs[v].has_par, vecs[v].pbit, vecs[v].stopv, 1,
                n, -1, -10, p0, p1);
      idle(4);
      check($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_buffull", v), 32'(buffull), 32'h1);
      check($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_fe));
      check($sformatf("v%0d_parity_err", v), 32'(parity_err), 32'(vecs[v].exp_pe));
      check($sformatf("v%0d_overrun", v), 32'(overrun), 32'h0);
      pulse_rd();
      check($sformatf("v%0d_rd_buffull", v), 32'(buffull), 32'h0);
      check($sformatf("v%0d_rd_flags", v), 32'({frame_err, parity_err}), 32'h0);
      check($sformatf("v%0d_rd_data_held", v), 32'(data), 32'(vecs[v].exp_data));
    end

    // Start-bit glitch of 4 ticks is rejected.
    wordlen = 4'd8; parity = 2'b00; u2x = 1'b0;
    idle(4);
    repeat (4) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(60);
    check("glitch_buffull", 32'(buffull), 32'h0);

    // Overrun: second frame discarded, first kept; buffull rises one clk after stop sample.
    send_word(9'h011, 8, 1'b0, 1'b0, 1'b1, 1, 16, -1, 155, p0, p1);
    check("latency_before", 32'(p0), 32'h0);
    check("latency_after", 32'(p1), 32'h1);
    idle(4);
    send_word(9'h022, 8, 1'b0, 1'b0, 1'b1, 1, 16, -1, -10, p0, p1);
    idle(4);
    check("ovr_data", 32'(data), 32'h011);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_buffull", 32'(buffull), 32'h1);
    pulse_rd();
    check("ovr_rd_flag", 32'(overrun), 32'h0);
    check("ovr_rd_buffull", 32'(buffull), 32'h0);

    // rd in the completion clock: read-then-load, no overrun.
    idle(4);
    send_word(9'h033, 8, 1'b0, 1'b0, 1'b1, 1, 16, -1, -10, p0, p1);
    idle(4);
    send_word(9'h044, 8, 1'b0, 1'b0, 1'b1, 1, 16, 155, -10, p0, p1);
    idle(4);
    check("rdcomp_data", 32'(data), 32'h044);
    check("rdcomp_overrun", 32'(overrun), 32'h0);
    check("rdcomp_buffull", 32'(buffull), 32'h1);

    // rxen low clears everything synchronously.
    @(negedge clk);
    rxen = 1'b0;
    idle(2);
    check("rxen_clear", 32'({data, buffull, overrun}), 32'h0);
    rxen = 1'b1;
    idle(4);

    // u2x, 9O2, back-to-back frames; first word read during the second frame.
    wordlen = 4'd9; parity = 2'b10; stopbits = 1'b1; u2x = 1'b1;
    idle(4);
    send_word(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 2, 8, -1, -10, p0, p1);
    check("b2b_first_data", 32'(data), 32'h1FF);
    check("b2b_first_flags", 32'({buffull, frame_err, parity_err, overrun}), 32'h8);
    send_word(9'h0F0, 9, 1'b1, 1'b1, 1'b1, 2, 8, 20, -10, p0, p1);
    idle(4);
    check("b2b_second_data", 32'(data), 32'h0F0);
    check("b2b_second_flags", 32'({buffull, frame_err, parity_err, overrun}), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
